// File: rtl/spi_master_cfg.sv
// spi_master_cfg: parametrised full-duplex SPI master with
// per-transfer CPOL/CPHA/bit order and multiple chip selects.
module spi_master_cfg #(
    parameter int DATA_W  = 8,
    parameter int NUM_CS  = 2,
    parameter int CLK_DIV = 2,
    parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_cs_n
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EW = $clog2(2 * DATA_W + 1);
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [EW-1:0]     ecnt_q, ecnt_d;
    logic              rdy_q, rdy_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [CS_W-1:0]   sel_q, sel_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              lsb_q, lsb_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              rxv_q, rxv_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic [NUM_CS-1:0] csn_q, csn_d;

    logic          accept;
    logic          cnt_last;
    logic          go;
    logic          sample;
    logic          drive;
    logic [BW-1:0] drv_k;
    logic [BW-1:0] smp_k;

    function automatic logic [BW-1:0] bit_pos(
        input logic          lsb,
        input logic [BW-1:0] k
    );
        bit_pos = lsb ? k : (BW'(DATA_W - 1) - k);
    endfunction

    // Out-of-range selects match no output, so no CS is driven.
    function automatic logic [NUM_CS-1:0] cs_dec(
        input logic [CS_W-1:0] s
    );
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (s == CS_W'(i)) cs_dec[i] = 1'b0;
        end
    endfunction

    assign accept   = tx_valid && rdy_q;
    assign cnt_last = (cnt_q == CNT_LAST);

    // ecnt_d is the number of the SCLK edge issued when go is high.
    assign drv_k  = BW'(ecnt_d >> 1);
    assign smp_k  = BW'((ecnt_d - 1'b1) >> 1);
    assign sample = go && (ecnt_d[0] != cpha_q);
    assign drive  = go && (ecnt_d[0] == cpha_q) && (ecnt_d != EDGE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ecnt_q  <= '0;
            rdy_q   <= 1'b0;
            tx_q    <= '0;
            sel_q   <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            rx_sh_q <= '0;
            rx_q    <= '0;
            rxv_q   <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            csn_q   <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ecnt_q  <= ecnt_d;
            rdy_q   <= rdy_d;
            tx_q    <= tx_d;
            sel_q   <= sel_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            rx_sh_q <= rx_sh_d;
            rx_q    <= rx_d;
            rxv_q   <= rxv_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            csn_q   <= csn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ecnt_d  = ecnt_q;
        go      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    ecnt_d  = '0;
                end
            end
            SETUP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_last) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    ecnt_d  = EW'(1);
                    go      = 1'b1;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_last) begin
                    cnt_d = '0;
                    if (ecnt_q == EDGE_LAST) begin
                        state_d = HOLD;
                    end else begin
                        ecnt_d = ecnt_q + 1'b1;
                        go     = 1'b1;
                    end
                end
            end
            HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        tx_d    = tx_q;
        sel_d   = sel_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        lsb_d   = lsb_q;
        rx_sh_d = rx_sh_q;
        rx_d    = rx_q;
        rxv_d   = 1'b0;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        rdy_d   = (state_d == IDLE);
        if (accept) begin
            tx_d    = tx_data;
            sel_d   = cs_sel;
            cpol_d  = cpol;
            cpha_d  = cpha;
            lsb_d   = lsb_first;
            rx_sh_d = '0;
            mosi_d  = tx_data[bit_pos(lsb_first, '0)];
        end
        unique case (state_q)
            IDLE, DONE: sclk_d = cpol;
            SETUP, SHIFT: if (go) sclk_d = ~sclk_q;
            HOLD: sclk_d = cpol_q;
            default: sclk_d = 1'b0;
        endcase
        if (sample) begin
            rx_sh_d[bit_pos(lsb_q, smp_k)] = spi_miso;
        end
        if (drive) begin
            mosi_d = tx_q[bit_pos(lsb_q, drv_k)];
        end
        if (state_q == HOLD && state_d == DONE) begin
            rx_d  = rx_sh_q;
            rxv_d = 1'b1;
        end
        csn_d = '1;
        if (state_d inside {SETUP, SHIFT, HOLD}) begin
            csn_d = cs_dec(sel_d);
        end
    end

    assign tx_ready = rdy_q;
    assign busy     = (state_q != IDLE);
    assign rx_data  = rx_q;
    assign rx_valid = rxv_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = csn_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg: directed checks of spi_master_cfg in an
// 8-bit/div-2 build and a 16-bit/div-1/3-CS build.
module tb_spi_master_cfg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [7:0]  tx_data0 = '0;
    logic        tx_valid0 = 1'b0;
    logic        tx_ready0;
    logic [0:0]  sel0 = '0;
    logic        cpol0 = 1'b0, cpha0 = 1'b0, lsb0 = 1'b0;
    logic [7:0]  rx_data0;
    logic        rx_valid0, busy0, sclk0, mosi0, miso0;
    logic [1:0]  cs0;

    logic [15:0] tx_data1 = '0;
    logic        tx_valid1 = 1'b0;
    logic        tx_ready1;
    logic [1:0]  sel1 = '0;
    logic        cpol1 = 1'b0, cpha1 = 1'b0, lsb1 = 1'b0;
    logic [15:0] rx_data1;
    logic        rx_valid1, busy1, sclk1, mosi1, miso1;
    logic [2:0]  cs1;

    logic       m0 = 1'b0, m1 = 1'b0, cap = 1'b0, slv_bit = 1'b0;
    logic [7:0] slv_word = '0, mos_seen = '0;
    int         slv_i = 0, mos_i = 0;

    int total = 0, bad = 0;
    int g_at, g_rdy, g_edges, g_lo0, g_lo1, g_nv, g_first, g_last;
    logic [15:0] g_rx;

    int         ecount, nv, frames, pulses, gap, mingap, lo0;
    logic       hit, prev_s, inlow;
    logic [7:0] v0, v1;

    assign miso0 = m0 ? slv_bit : mosi0;
    assign miso1 = m1 ? 1'b1 : mosi1;

    always #5 clk = ~clk;

    spi_master_cfg #(.DATA_W(8), .NUM_CS(2), .CLK_DIV(2)) u0 (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .cs_sel(sel0), .cpol(cpol0), .cpha(cpha0), .lsb_first(lsb0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0),
        .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_miso(miso0),
        .spi_cs_n(cs0)
    );

    spi_master_cfg #(.DATA_W(16), .NUM_CS(3), .CLK_DIV(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .cs_sel(sel1), .cpol(cpol1), .cpha(cpha1), .lsb_first(lsb1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1),
        .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso1),
        .spi_cs_n(cs1)
    );

    // Mode-3 slave: present next bit on the leading (falling) edge.
    always @(negedge sclk0) begin
        if (m0 && !cs0[0] && slv_i < 8) begin
            slv_bit = slv_word[slv_i];
            slv_i++;
        end
    end

    always @(posedge sclk0) begin
        if (cap && !cs0[0] && mos_i < 8) begin
            mos_seen[mos_i] = mosi0;
            mos_i++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic xfer0(input logic [7:0] d, input logic s,
                         input logic pol, input logic pha, input logic lsb);
        logic prev;
        @(negedge clk);
        chk("ready0_before", tx_ready0, 1);
        tx_data0 = d; sel0 = s; cpol0 = pol; cpha0 = pha; lsb0 = lsb;
        tx_valid0 = 1'b1;
        prev = sclk0;
        g_at = 0; g_rdy = 0; g_edges = 0; g_lo0 = 0; g_lo1 = 0; g_nv = 0;
        g_rx = '0;
        @(posedge clk);
        @(negedge clk);
        tx_valid0 = 1'b0;
        for (int n = 1; n <= 200 && g_rdy == 0; n++) begin
            if (n > 1) @(negedge clk);
            if (sclk0 != prev) g_edges++;
            prev = sclk0;
            if (!cs0[0]) g_lo0++;
            if (!cs0[1]) g_lo1++;
            if (rx_valid0) begin
                g_nv++; g_at = n; g_rx = 16'(rx_data0);
            end
            if (tx_ready0 && g_at != 0) g_rdy = n;
        end
        chk("xfer0_finished", g_rdy != 0, 1);
    endtask

    task automatic xfer1(input logic [15:0] d, input logic [1:0] s,
                         input logic pha);
        logic prev;
        @(negedge clk);
        chk("ready1_before", tx_ready1, 1);
        tx_data1 = d; sel1 = s; cpol1 = 1'b0; cpha1 = pha; lsb1 = 1'b0;
        tx_valid1 = 1'b1;
        prev = sclk1;
        g_at = 0; g_rdy = 0; g_edges = 0; g_lo0 = 0; g_nv = 0;
        g_first = 0; g_last = 0; g_rx = '0;
        @(posedge clk);
        @(negedge clk);
        tx_valid1 = 1'b0;
        for (int n = 1; n <= 200 && g_rdy == 0; n++) begin
            if (n > 1) @(negedge clk);
            if (sclk1 != prev) begin
                g_edges++;
                if (g_first == 0) g_first = n;
                g_last = n;
            end
            prev = sclk1;
            if (cs1 != 3'b111) g_lo0++;
            if (rx_valid1) begin
                g_nv++; g_at = n; g_rx = rx_data1;
            end
            if (tx_ready1 && g_at != 0) g_rdy = n;
        end
        chk("xfer1_finished", g_rdy != 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", tx_ready0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_cs_n", cs0, 2'b11);
        chk("rst_sclk", sclk0, 0);
        chk("rst_mosi", mosi0, 0);
        chk("rst_rx", {rx_valid0, rx_data0}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", tx_ready0, 1);

        // mode 0, MSB first, loopback
        xfer0(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("m0_edges", g_edges, 16);
        chk("m0_cs0_low", g_lo0, 36);
        chk("m0_cs1_low", g_lo1, 0);
        chk("m0_rx_at", g_at, 37);
        chk("m0_rx", g_rx, 16'h00A5);
        chk("m0_ready_at", g_rdy, 38);
        chk("m0_nvalid", g_nv, 1);

        // mode 3, LSB first, slave returns 0x81
        m0 = 1'b1; cap = 1'b1; slv_word = 8'h81; slv_i = 0; mos_i = 0;
        @(negedge clk);
        cpol0 = 1'b1;
        repeat (2) @(negedge clk);
        chk("m3_idle_high", sclk0, 1);
        xfer0(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("m3_mosi_seq", mos_seen, 8'h3C);
        chk("m3_rx", g_rx, 16'h0081);
        chk("m3_edges", g_edges, 16);
        chk("m3_sclk_end", sclk0, 1);
        cap = 1'b0; m0 = 1'b0; cpol0 = 1'b0;
        repeat (2) @(negedge clk);

        // back-to-back on cs 1 with tx_valid held high
        @(negedge clk);
        tx_data0 = 8'h01; sel0 = 1'b1; cpha0 = 1'b0; lsb0 = 1'b0;
        tx_valid0 = 1'b1;
        frames = 0; pulses = 0; gap = 0; mingap = 1000; lo0 = 0;
        inlow = 1'b0; v0 = '0; v1 = '0;
        @(posedge clk);
        @(negedge clk);
        tx_data0 = 8'h02;
        for (int n = 1; n <= 300 && pulses < 2; n++) begin
            if (n > 1) @(negedge clk);
            if (!cs0[1]) begin
                if (!inlow) begin
                    frames++;
                    if (frames > 1 && gap < mingap) mingap = gap;
                end
                inlow = 1'b1;
            end else begin
                if (inlow) gap = 0;
                inlow = 1'b0;
                gap++;
            end
            if (!cs0[0]) lo0++;
            if (rx_valid0) begin
                if (pulses == 0) v0 = rx_data0;
                else v1 = rx_data0;
                pulses++;
                if (pulses == 2) tx_valid0 = 1'b0;
            end
        end
        chk("b2b_frames", frames, 2);
        chk("b2b_pulses", pulses, 2);
        chk("b2b_rx_first", v0, 8'h01);
        chk("b2b_rx_second", v1, 8'h02);
        chk("b2b_cs0_idle", lo0, 0);
        chk("b2b_gap_ge2", mingap >= 2, 1);
        repeat (4) @(negedge clk);
        chk("b2b_no_third", busy0, 0);

        // reset during edge 7
        @(negedge clk);
        tx_data0 = 8'hA5; sel0 = 1'b0; cpol0 = 1'b0; cpha0 = 1'b0;
        lsb0 = 1'b0; tx_valid0 = 1'b1;
        prev_s = sclk0; ecount = 0; nv = 0; hit = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tx_valid0 = 1'b0;
        for (int n = 0; n < 100 && !hit; n++) begin
            if (n > 0) @(negedge clk);
            if (sclk0 != prev_s) ecount++;
            prev_s = sclk0;
            if (rx_valid0) nv++;
            if (ecount == 7) hit = 1'b1;
        end
        chk("rst_edge7_seen", hit, 1);
        chk("rst_sclk_high_before", sclk0, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cs_n", cs0, 2'b11);
        chk("rst_mid_sclk", sclk0, 0);
        chk("rst_mid_busy", busy0, 0);
        repeat (3) begin
            @(negedge clk);
            if (rx_valid0) nv++;
        end
        rst_n = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (rx_valid0) nv++;
        end
        chk("rst_no_rx_valid", nv, 0);
        xfer0(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_after_rx", g_rx, 16'h00FF);
        chk("rst_after_nvalid", g_nv, 1);

        // select beyond NUM_CS, miso tied high
        m1 = 1'b1;
        xfer1(16'h1234, 2'd3, 1'b0);
        chk("oor_cs_idle", g_lo0, 0);
        chk("oor_rx", g_rx, 16'hFFFF);
        chk("oor_nvalid", g_nv, 1);
        chk("oor_rx_at", g_at, 35);

        // 16-bit, div 1, mode 1, loopback
        m1 = 1'b0;
        xfer1(16'hBEEF, 2'd0, 1'b1);
        chk("w16_rx", g_rx, 16'hBEEF);
        chk("w16_rx_at", g_at, 35);
        chk("w16_edges", g_edges, 32);
        chk("w16_first_edge", g_first, 2);
        chk("w16_last_edge", g_last, 33);
        chk("w16_cs_low", g_lo0, 34);
        chk("w16_ready_at", g_rdy, 36);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
